// File: rtl/shape_dispatcher.sv
// shape_dispatcher: buffers host shape opcodes in a small FIFO and issues them
// to the ComputationalCore one at a time. Each pixel from the core becomes a
// frame-buffer SRAM write, and the core is released only after the write is
// acknowledged. Completed shapes are counted, and busy/queue status is reported.
//
// Handshakes:
//   host -> FIFO : a push happens on a rising edge where op_valid && op_ready.
//                  op_ready is registered and is low only while the FIFO is full.
//   core -> us   : core_data_ready is a level held until core_data_sent pulses.
//                  core_shape_done is a level held until the next core_new_shape.
//                  Both are sampled only in RUN.
//   us -> SRAM   : mem_wr_req is held with stable mem_addr/mem_wdata until the
//                  one-cycle mem_wr_ack. The request drops in the following cycle.
module shape_dispatcher #(
    parameter int QUEUE_DEPTH = 4,
    parameter int OPCODE_W    = 96,
    parameter int ADDR_W      = 19,
    parameter int COLOR_W     = 16,
    localparam int PTR_W      = $clog2(QUEUE_DEPTH),
    localparam int CNT_W      = PTR_W + 1
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                op_valid,
    input  logic [OPCODE_W-1:0] op_data,
    output logic                op_ready,
    output logic                core_new_shape,
    output logic [OPCODE_W-1:0] core_opcode,
    input  logic                core_data_ready,
    input  logic [ADDR_W-1:0]   core_address,
    input  logic [COLOR_W-1:0]  core_color,
    input  logic                core_frame_target,
    input  logic                core_shape_done,
    output logic                core_data_sent,
    output logic                mem_wr_req,
    output logic [ADDR_W:0]     mem_addr,
    output logic [COLOR_W-1:0]  mem_wdata,
    input  logic                mem_wr_ack,
    output logic                busy,
    output logic [CNT_W-1:0]    queue_count,
    output logic [15:0]         shapes_done_cnt,
    output logic [2:0]          dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_RUN   = 3'd2,
        S_WRITE = 3'd3,
        S_SENT  = 3'd4
    } state_t;

    state_t               state_q, state_d;

    logic [OPCODE_W-1:0]  fifo_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 op_ready_q, op_ready_d;

    logic [OPCODE_W-1:0]  core_opcode_q, core_opcode_d;
    logic [ADDR_W:0]      mem_addr_q, mem_addr_d;
    logic [COLOR_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [15:0]          shapes_done_cnt_q, shapes_done_cnt_d;

    logic                 push;
    logic                 pop;

    // Push/pop qualifiers: the host is gated by the registered ready, and only IDLE pops.
    always_comb begin
        push = op_valid && op_ready_q;
        pop  = (state_q == S_IDLE) && (count_q != '0);
    end

    // FIFO pointer and occupancy update. Pointers wrap naturally (depth is a power of two).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        op_ready_d = (count_d != CNT_W'(QUEUE_DEPTH));
    end

    // FIFO storage. It needs no reset because the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= op_data;
        end
    end

    // Next-state logic. In RUN a pending pixel wins over shape completion.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (count_q != '0) state_d = S_ISSUE;
            S_ISSUE: state_d = S_RUN;
            S_RUN: begin
                if (core_data_ready) begin
                    state_d = S_WRITE;
                end else if (core_shape_done) begin
                    state_d = S_IDLE;
                end
            end
            S_WRITE: if (mem_wr_ack) state_d = S_SENT;
            S_SENT:  state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath registers: load the opcode on pop, capture the pixel on leaving RUN, count completions.
    always_comb begin
        core_opcode_d     = core_opcode_q;
        mem_addr_d        = mem_addr_q;
        mem_wdata_d       = mem_wdata_q;
        shapes_done_cnt_d = shapes_done_cnt_q;
        if (pop) begin
            core_opcode_d = fifo_mem[rd_ptr_q];
        end
        if (state_q == S_RUN) begin
            if (core_data_ready) begin
                mem_addr_d  = {core_frame_target, core_address};
                mem_wdata_d = core_color;
            end else if (core_shape_done) begin
                shapes_done_cnt_d = shapes_done_cnt_q + 16'd1;
            end
        end
    end

    // Outputs decoded from the state register, so the write request clears with an async reset.
    always_comb begin
        core_new_shape = (state_q == S_ISSUE);
        core_data_sent = (state_q == S_SENT);
        mem_wr_req     = (state_q == S_WRITE);
        busy           = (state_q != S_IDLE) || (count_q != '0);
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q           <= S_IDLE;
            wr_ptr_q          <= '0;
            rd_ptr_q          <= '0;
            count_q           <= '0;
            op_ready_q        <= 1'b1;
            core_opcode_q     <= '0;
            mem_addr_q        <= '0;
            mem_wdata_q       <= '0;
            shapes_done_cnt_q <= '0;
        end else begin
            state_q           <= state_d;
            wr_ptr_q          <= wr_ptr_d;
            rd_ptr_q          <= rd_ptr_d;
            count_q           <= count_d;
            op_ready_q        <= op_ready_d;
            core_opcode_q     <= core_opcode_d;
            mem_addr_q        <= mem_addr_d;
            mem_wdata_q       <= mem_wdata_d;
            shapes_done_cnt_q <= shapes_done_cnt_d;
        end
    end

    assign op_ready        = op_ready_q;
    assign core_opcode     = core_opcode_q;
    assign mem_addr        = mem_addr_q;
    assign mem_wdata       = mem_wdata_q;
    assign queue_count     = count_q;
    assign shapes_done_cnt = shapes_done_cnt_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_shape_dispatcher.sv
// Directed testbench for shape_dispatcher. Inputs change on the falling edge
// and outputs are sampled there, half a cycle away from the active edge.
module tb_shape_dispatcher;

    localparam int QD   = 4;
    localparam int OW   = 96;
    localparam int AW   = 19;
    localparam int CW   = 16;
    localparam int CNTW = 3;

    logic            clk = 1'b0;
    logic            n_rst = 1'b0;
    logic            op_valid = 1'b0;
    logic [OW-1:0]   op_data = '0;
    logic            op_ready;
    logic            core_new_shape;
    logic [OW-1:0]   core_opcode;
    logic            core_data_ready = 1'b0;
    logic [AW-1:0]   core_address = '0;
    logic [CW-1:0]   core_color = '0;
    logic            core_frame_target = 1'b0;
    logic            core_shape_done = 1'b0;
    logic            core_data_sent;
    logic            mem_wr_req;
    logic [AW:0]     mem_addr;
    logic [CW-1:0]   mem_wdata;
    logic            mem_wr_ack = 1'b0;
    logic            busy;
    logic [CNTW-1:0] queue_count;
    logic [15:0]     shapes_done_cnt;
    logic [2:0]      dbg_state;

    int err_cnt  = 0;
    int chk_cnt  = 0;
    int ns_cnt   = 0;
    int sent_cnt = 0;
    logic [OW-1:0] issued_q[$];
    logic [OW-1:0] exp_q[$];

    // Clock generation
    always #5 clk = ~clk;

    shape_dispatcher #(
        .QUEUE_DEPTH(QD),
        .OPCODE_W   (OW),
        .ADDR_W     (AW),
        .COLOR_W    (CW)
    ) dut (
        .clk              (clk),
        .n_rst            (n_rst),
        .op_valid         (op_valid),
        .op_data          (op_data),
        .op_ready         (op_ready),
        .core_new_shape   (core_new_shape),
        .core_opcode      (core_opcode),
        .core_data_ready  (core_data_ready),
        .core_address     (core_address),
        .core_color       (core_color),
        .core_frame_target(core_frame_target),
        .core_shape_done  (core_shape_done),
        .core_data_sent   (core_data_sent),
        .mem_wr_req       (mem_wr_req),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_wr_ack       (mem_wr_ack),
        .busy             (busy),
        .queue_count      (queue_count),
        .shapes_done_cnt  (shapes_done_cnt),
        .dbg_state        (dbg_state)
    );

    // Monitor: counts pulses and records each issued opcode
    always @(posedge clk) begin
        if (core_new_shape) begin
            ns_cnt = ns_cnt + 1;
            issued_q.push_back(core_opcode);
        end
        if (core_data_sent) begin
            sent_cnt = sent_cnt + 1;
        end
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // which: 0 new_shape, 1 mem_wr_req, 2 idle, 3 new_shape or idle
    task automatic wait_until(input int which, input int budget, input string tag);
        int  n;
        bit  hit;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < budget) begin
            case (which)
                0:       hit = core_new_shape;
                1:       hit = mem_wr_req;
                2:       hit = !busy;
                3:       hit = core_new_shape || !busy;
                default: hit = 1'b1;
            endcase
            if (!hit) begin
                @(negedge clk);
                n++;
            end
        end
        if (!hit) check_val({tag, "_timeout"}, 128'd0, 128'd1);
    endtask

    task automatic push_op(input logic [OW-1:0] d);
        int n;
        n = 0;
        while (!op_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        op_valid = 1'b1;
        op_data  = d;
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    // Presents one pixel, answers the write after ack_delay stall cycles, and checks the release.
    task automatic write_pixel(input logic frame, input logic [AW-1:0] addr,
                               input logic [CW-1:0] color, input int ack_delay,
                               input string tag);
        int req_cycles;
        int sent0;
        core_data_ready   = 1'b1;
        core_frame_target = frame;
        core_address      = addr;
        core_color        = color;
        mem_wr_ack        = 1'b0;
        @(negedge clk);
        wait_until(1, 10, tag);
        sent0      = sent_cnt;
        req_cycles = 0;
        for (int i = 0; i <= ack_delay; i++) begin
            if (mem_wr_req) req_cycles++;
            check_val({tag, "_addr"}, 128'(mem_addr), 128'({frame, addr}));
            check_val({tag, "_wdata"}, 128'(mem_wdata), 128'(color));
            if (i == ack_delay) mem_wr_ack = 1'b1;
            @(negedge clk);
        end
        mem_wr_ack      = 1'b0;
        core_data_ready = 1'b0;
        check_val({tag, "_sent_pulse"}, 128'(core_data_sent), 128'd1);
        check_val({tag, "_req_dropped"}, 128'(mem_wr_req), 128'd0);
        check_val({tag, "_req_cycles"}, 128'(req_cycles), 128'(ack_delay + 1));
        @(negedge clk);
        check_val({tag, "_sent_low"}, 128'(core_data_sent), 128'd0);
        check_val({tag, "_sent_count"}, 128'(sent_cnt - sent0), 128'd1);
    endtask

    initial begin
        int ns0;
        int sent0;

        // ---------------- reset with random inputs ----------------
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            op_valid          = 1'($urandom_range(0, 1));
            op_data           = {$urandom(), $urandom(), $urandom()};
            core_data_ready   = 1'($urandom_range(0, 1));
            core_shape_done   = 1'($urandom_range(0, 1));
            core_address      = 19'($urandom());
            core_color        = 16'($urandom());
            core_frame_target = 1'($urandom_range(0, 1));
            mem_wr_ack        = 1'($urandom_range(0, 1));
        end
        check_val("rst_op_ready", 128'(op_ready), 128'd1);
        check_val("rst_busy", 128'(busy), 128'd0);
        check_val("rst_req", 128'(mem_wr_req), 128'd0);
        check_val("rst_qcount", 128'(queue_count), 128'd0);
        check_val("rst_done_cnt", 128'(shapes_done_cnt), 128'd0);
        check_val("rst_new_shape", 128'(core_new_shape), 128'd0);
        check_val("rst_sent", 128'(core_data_sent), 128'd0);
        check_val("rst_opcode", 128'(core_opcode), 128'd0);
        check_val("rst_mem_addr", 128'(mem_addr), 128'd0);
        op_valid = 1'b0; core_data_ready = 1'b0; core_shape_done = 1'b0;
        mem_wr_ack = 1'b0; core_frame_target = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);

        // ---------------- single shape, two pixels ----------------
        ns0   = ns_cnt;
        sent0 = sent_cnt;
        push_op(96'h1);
        wait_until(0, 10, "s1_issue");
        check_val("s1_opcode", 128'(core_opcode), 128'h1);
        write_pixel(1'b1, 19'h00010, 16'hF800, 0, "s1_pixA");
        check_val("s1_pixA_busy", 128'(busy), 128'd1);
        write_pixel(1'b0, 19'h7FFFF, 16'h001F, 0, "s1_pixB");
        core_shape_done = 1'b1;
        wait_until(2, 10, "s1_idle");
        check_val("s1_done_cnt", 128'(shapes_done_cnt), 128'd1);
        check_val("s1_sent_total", 128'(sent_cnt - sent0), 128'd2);
        check_val("s1_new_shapes", 128'(ns_cnt - ns0), 128'd1);
        check_val("s1_busy", 128'(busy), 128'd0);

        // ---------------- memory stall ----------------
        push_op(96'h2);
        wait_until(0, 10, "st_issue");
        core_shape_done = 1'b0;
        check_val("st_opcode", 128'(core_opcode), 128'h2);
        write_pixel(1'b0, 19'h12345, 16'h07E0, 3, "st_pix");
        core_shape_done = 1'b1;
        wait_until(2, 10, "st_idle");
        check_val("st_done_cnt", 128'(shapes_done_cnt), 128'd2);

        // ---------------- backpressure ----------------
        core_shape_done = 1'b0;
        issued_q.delete();
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(96'hA0 + 96'(i));
            push_op(96'hA0 + 96'(i));
        end
        op_valid = 1'b1;
        op_data  = 96'hBAD;
        for (int i = 0; i < 3; i++) begin
            check_val("bp_qcount", 128'(queue_count), 128'd4);
            check_val("bp_op_ready", 128'(op_ready), 128'd0);
            @(negedge clk);
        end
        op_valid = 1'b0;
        check_val("bp_first_issued", 128'(issued_q.size()), 128'd1);
        for (int i = 0; i < 5; i++) begin
            core_shape_done = 1'b1;
            @(negedge clk);
            wait_until(3, 10, "bp_complete");
            core_shape_done = 1'b0;
            @(negedge clk);
        end
        wait_until(2, 10, "bp_idle");
        check_val("bp_issued_count", 128'(issued_q.size()), 128'd5);
        while (exp_q.size() > 0 && issued_q.size() > 0) begin
            check_val("bp_order", 128'(issued_q.pop_front()), 128'(exp_q.pop_front()));
        end
        check_val("bp_done_cnt", 128'(shapes_done_cnt), 128'd7);
        check_val("bp_qcount_end", 128'(queue_count), 128'd0);

        // ---------------- simultaneous data_ready/shape_done, counter wrap ----------------
        force dut.shapes_done_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.shapes_done_cnt_q;
        @(negedge clk);
        check_val("wr_preset", 128'(shapes_done_cnt), 128'hFFFF);
        push_op(96'h5);
        wait_until(0, 10, "wr_issue");
        check_val("wr_opcode", 128'(core_opcode), 128'h5);
        core_shape_done = 1'b1;
        write_pixel(1'b1, 19'h00ABC, 16'hFFFF, 0, "wr_pix");
        check_val("wr_cnt_after_sent", 128'(shapes_done_cnt), 128'hFFFF);
        wait_until(2, 10, "wr_idle");
        check_val("wr_wrapped", 128'(shapes_done_cnt), 128'h0);
        core_shape_done = 1'b0;
        @(negedge clk);

        // ---------------- reset mid-WRITE with 2 opcodes queued ----------------
        push_op(96'h7);
        wait_until(0, 10, "rw_issue");
        push_op(96'h8);
        push_op(96'h9);
        core_data_ready   = 1'b1;
        core_frame_target = 1'b0;
        core_address      = 19'h00100;
        core_color        = 16'h1234;
        @(negedge clk);
        wait_until(1, 10, "rw_req");
        check_val("rw_qcount_before", 128'(queue_count), 128'd2);
        n_rst = 1'b0;
        #1;
        check_val("rw_req_drop", 128'(mem_wr_req), 128'd0);
        check_val("rw_qcount_flush", 128'(queue_count), 128'd0);
        check_val("rw_busy", 128'(busy), 128'd0);
        check_val("rw_op_ready", 128'(op_ready), 128'd1);
        core_data_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        ns0   = ns_cnt;
        repeat (8) @(negedge clk);
        check_val("rw_no_new_shape", 128'(ns_cnt - ns0), 128'd0);
        check_val("rw_qcount_after", 128'(queue_count), 128'd0);
        check_val("rw_busy_after", 128'(busy), 128'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
